// File: rtl/gpu_reg_arbiter.sv
// gpu_reg_arbiter
// Two-requester write arbiter in front of the GPU register port.
// A requester is granted first. It may then keep the grant with Lock for up
// to LOCK_MAX beats. Each accepted beat is presented on the registered GPU
// port for exactly one cycle.

module gpu_reg_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  req0Valid,
    input  logic                  req1Valid,
    input  logic                  req0Lock,
    input  logic                  req1Lock,
    input  logic [ADDR_WIDTH-1:0] req0Addr,
    input  logic [ADDR_WIDTH-1:0] req1Addr,
    input  logic [3:0]            req0Strb,
    input  logic [3:0]            req1Strb,
    input  logic [31:0]           req0Data,
    input  logic [31:0]           req1Data,
    output logic                  req0Ready,
    output logic                  req1Ready,
    input  logic                  gpuBusy,
    output logic [ADDR_WIDTH-1:0] gpuAddr,
    output logic [3:0]            gpuStrb,
    output logic [31:0]           gpuData,
    output logic [1:0]            grantOwner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    state_t     state_r;
    state_t     state_s;
    logic       last_served_r;
    logic       last_served_s;
    logic [7:0] lock_count_r;
    logic [7:0] lock_count_s;
    logic       own_id_s;
    logic       own_valid_s;
    logic       own_lock_s;
    logic       cap_hit_s;
    logic       accept_s;

    // Ready is combinational so a beat is taken in the same cycle the GPU frees up
    assign req0Ready = (state_r == ST_OWN0) & ~gpuBusy;
    assign req1Ready = (state_r == ST_OWN1) & ~gpuBusy;
    assign accept_s  = (req0Valid & req0Ready) | (req1Valid & req1Ready);

    // Select the current owner's request controls
    always_comb begin
        own_id_s    = 1'b0;
        own_valid_s = 1'b0;
        own_lock_s  = 1'b0;
        case (state_r)
            ST_OWN0: begin
                own_id_s    = 1'b0;
                own_valid_s = req0Valid;
                own_lock_s  = req0Lock;
            end
            ST_OWN1: begin
                own_id_s    = 1'b1;
                own_valid_s = req1Valid;
                own_lock_s  = req1Lock;
            end
            default: begin
                own_id_s    = 1'b0;
                own_valid_s = 1'b0;
                own_lock_s  = 1'b0;
            end
        endcase
    end

    // The next beat or hold cycle would reach the lock cap
    assign cap_hit_s = ((lock_count_r + 8'd1) == LOCK_MAX_C);

    // Next-state, fairness and lock-count logic
    always_comb begin
        state_s       = state_r;
        last_served_s = last_served_r;
        lock_count_s  = lock_count_r;
        case (state_r)
            ST_IDLE: begin
                lock_count_s = 8'd0;
                if (req0Valid && req1Valid) begin
                    state_s = last_served_r ? ST_OWN0 : ST_OWN1;
                end else if (req0Valid) begin
                    state_s = ST_OWN0;
                end else if (req1Valid) begin
                    state_s = ST_OWN1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (gpuBusy) begin
                    state_s = state_r;
                end else if (own_lock_s) begin
                    // A locked beat, or a locked hold without a beat, uses one lock slot
                    if (cap_hit_s) begin
                        state_s       = ST_IDLE;
                        last_served_s = own_id_s;
                        lock_count_s  = 8'd0;
                    end else begin
                        lock_count_s = lock_count_r + 8'd1;
                    end
                end else if (own_valid_s) begin
                    state_s       = ST_IDLE;
                    last_served_s = own_id_s;
                    lock_count_s  = 8'd0;
                end else begin
                    // Withdrawn without lock: release and leave fairness untouched
                    state_s      = ST_IDLE;
                    lock_count_s = 8'd0;
                end
            end
            default: begin
                state_s       = ST_IDLE;
                last_served_s = 1'b1;
                lock_count_s  = 8'd0;
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r       <= ST_IDLE;
            last_served_r <= 1'b1;
            lock_count_r  <= 8'd0;
            grantOwner    <= 2'b00;
        end else begin
            state_r       <= state_s;
            last_served_r <= last_served_s;
            lock_count_r  <= lock_count_s;
            grantOwner    <= {(state_s == ST_OWN1), (state_s == ST_OWN0)};
        end
    end

    // GPU port: each accepted beat appears for one cycle; address and data hold afterwards
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gpuAddr <= {ADDR_WIDTH{1'b0}};
            gpuStrb <= 4'b0000;
            gpuData <= 32'h0000_0000;
        end else if (accept_s) begin
            gpuAddr <= own_id_s ? req1Addr : req0Addr;
            gpuStrb <= own_id_s ? req1Strb : req0Strb;
            gpuData <= own_id_s ? req1Data : req0Data;
        end else begin
            gpuStrb <= 4'b0000;
        end
    end

endmodule

// File: doc/gpu_reg_arbiter.md
GPU_REG_ARBITER -- requirements
Module: gpu_reg_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 8, setting the GPU register word-address width.
REQ-002 The module SHALL have parameter LOCK_MAX, default 16, setting the maximum beats per locked grant (range 1..255).
REQ-003 HCLK  input  1  single clock; all state on rising edge.
REQ-004 HRESETn  input  1  asynchronous, active-low reset.
REQ-005 req0Valid, req1Valid  input  1 each  requester i has a write beat pending.
REQ-006 req0Lock, req1Lock  input  1 each  requester i asks to keep the grant after the current beat.
REQ-007 req0Addr, req1Addr  input  ADDR_WIDTH each  GPU register word address.
REQ-008 req0Strb, req1Strb  input  4 each  byte-lane write enables.
REQ-009 req0Data, req1Data  input  32 each  write data.
REQ-010 req0Ready, req1Ready  output  1 each  beat accepted when Valid and Ready are both high on a rising edge.
REQ-011 gpuBusy  input  1  GPU cannot take register writes this cycle.
REQ-012 gpuAddr  output  ADDR_WIDTH  registered register address to the GPU.
REQ-013 gpuStrb  output  4  registered byte enables; all-zero means no write.
REQ-014 gpuData  output  32  registered write data.
REQ-015 grantOwner  output  2  one-hot current owner; 00 when idle.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1.
REQ-017 In IDLE with exactly one Valid high, the FSM SHALL move to that requester's OWN state on the next edge.
REQ-018 In IDLE with both Valid high, the FSM SHALL grant the requester not served last; lastServed resets to 1, so requester 0 wins the first tie.
REQ-019 reqiReady SHALL equal (state==OWNi) & ~gpuBusy; it SHALL be combinational and SHALL never be high in IDLE or for the non-owner.
REQ-020 An accepted beat at edge N SHALL drive gpuAddr, gpuData and gpuStrb (the beat's Strb) during cycle N+1 only.
REQ-021 gpuStrb SHALL be 0000 in any cycle not following an accepted beat; gpuAddr and gpuData SHALL hold their previous values.
REQ-022 A beat with Strb=0000 SHALL still be accepted and counted; it produces gpuStrb=0000 (no write).
REQ-023 In OWNi, an accepted beat with reqiLock low SHALL return the FSM to IDLE and set lastServed=i.
REQ-024 In OWNi, an accepted beat with reqiLock high SHALL keep OWNi and increment an 8-bit lockCount; lockCount is cleared on every entry to OWN.
REQ-025 When an accepted beat brings lockCount to LOCK_MAX, the FSM SHALL return to IDLE regardless of reqiLock.
REQ-026 In OWNi with reqiValid low and reqiLock low, the FSM SHALL return to IDLE on the next edge without recording lastServed.
REQ-027 In OWNi with reqiValid low and reqiLock high, the FSM SHALL hold OWNi; the hold counts toward LOCK_MAX as one beat per cycle.
REQ-028 While gpuBusy is high, the FSM SHALL hold its state; lockCount SHALL not advance and no beat SHALL be accepted.
REQ-029 In IDLE, a requester's Lock SHALL be ignored until its Valid is high.
REQ-030 grantOwner SHALL be the registered one-hot encoding of the FSM state.
REQ-031 Minimum IDLE-to-first-write latency SHALL be 2 cycles: grant edge, then accept edge; gpuStrb is valid in the following cycle.

Reset
REQ-032 While HRESETn is low, the block SHALL force state=IDLE, lastServed=1, lockCount=0, gpuAddr=0, gpuStrb=0000, gpuData=0, grantOwner=00 and both Ready outputs to 0.
REQ-033 Reset asserted mid-grant or mid-beat SHALL discard any unissued beat with no partial GPU write.
REQ-034 After HRESETn deasserts, arbitration SHALL restart as in REQ-018.

Verification
REQ-035 Single write: req0 Valid, Addr=0x12, Strb=1111, Data=0xDEADBEEF, Lock=0 -> grantOwner=01 next cycle; beat accepted; one cycle later gpuAddr=0x12, gpuStrb=1111, gpuData=0xDEADBEEF; then gpuStrb=0000 and grantOwner=00.
REQ-036 Tie and fairness: both Valid continuously, Lock=0 -> grants alternate 0,1,0,1; each beat appears once on the GPU port in grant order.
REQ-037 Lock cap: LOCK_MAX=4, req1 Lock=1 with 10 beats and req0 Valid -> exactly 4 req1 beats, IDLE, one req0 beat, then req1 resumes.
REQ-038 Back-pressure: gpuBusy high for 5 cycles during OWN0 -> req0Ready=0 and gpuStrb=0000 throughout; the held beat is issued on the first edge after gpuBusy falls, unchanged.
REQ-039 Reset mid-beat: HRESETn low on the cycle a req1 beat is accepted -> gpuStrb=0000 and all outputs at reset values; no write is issued after release.
REQ-040 Withdrawal: grant req0, then req0Valid drops with Lock=0 -> IDLE next cycle; a pending req1 is granted on the following edge.
